// File: rtl/shared_reg_arbiter_if.sv
// Bus bundle between the requesters and the shared-register arbiter.
// The requester side uses the master modport; the arbiter uses the slave modport.
interface shared_reg_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    ack;
  logic [IDW-1:0]     gnt_id;
  logic               busy;
  logic [DW-1:0]      q;

  modport master (
    output req, wdata, lock,
    input  ack, gnt_id, busy, q
  );

  modport slave (
    input  req, wdata, lock,
    output ack, gnt_id, busy, q
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter owning one shared DW-bit register (IDLE -> WRITE -> ACK).
// Optional grant retention is enabled by defining SHREG_LOCK_EN.
module shared_reg_arbiter #(
  parameter int            NREQ    = 4,
  parameter int            DW      = 8,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  shared_reg_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_q, w_q_nxt;
  logic [DW-1:0]   r_data, w_data_nxt;
  logic [NREQ-1:0] r_ack, w_ack_nxt;
  logic [IDW-1:0]  r_gnt_id, w_gnt_id_nxt;
  logic [IDW-1:0]  r_rr_ptr, w_rr_ptr_nxt;

  logic [DW-1:0]   w_wdata_arr [NREQ];
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_rr_win;
  logic            w_rr_hit;
  logic            w_hold_hit;
  logic [IDW-1:0]  w_win;

`ifdef SHREG_LOCK_EN
  logic r_held, w_held_nxt;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_wdata_arr[g] = bus.wdata[g*DW +: DW];
  end

  // Scan from the farthest candidate back to rr_ptr+1 so the nearest requester is assigned last and wins.
  always_comb begin
    w_rr_win = r_rr_ptr;
    w_rr_hit = 1'b0;
    w_idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (bus.req[w_idx]) begin
        w_rr_win = w_idx;
        w_rr_hit = 1'b1;
      end
    end
  end

`ifdef SHREG_LOCK_EN
  assign w_hold_hit = r_held && bus.req[r_gnt_id];
`else
  assign w_hold_hit = 1'b0;
`endif

  assign w_win = w_hold_hit ? r_gnt_id : w_rr_win;

  // NOTE: every next-state variable gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_data_nxt   = r_data;
    w_ack_nxt    = r_ack;
    w_gnt_id_nxt = r_gnt_id;
    w_rr_ptr_nxt = r_rr_ptr;
`ifdef SHREG_LOCK_EN
    w_held_nxt   = r_held;
`endif
    unique case (r_state)
      S_IDLE: begin
`ifdef SHREG_LOCK_EN
        if (r_held && !bus.req[r_gnt_id]) w_held_nxt = 1'b0;
`endif
        if (w_hold_hit || w_rr_hit) begin
          w_gnt_id_nxt = w_win;
          w_data_nxt   = w_wdata_arr[w_win];
          w_state_nxt  = S_WRITE;
        end
      end
      S_WRITE: begin
        w_q_nxt             = r_data;
        w_ack_nxt           = '0;
        w_ack_nxt[r_gnt_id] = 1'b1;
        w_state_nxt         = S_ACK;
      end
      S_ACK: begin
        w_ack_nxt   = '0;
        w_state_nxt = S_IDLE;
`ifdef SHREG_LOCK_EN
        if (bus.lock[r_gnt_id]) begin
          w_held_nxt = 1'b1;
        end else begin
          w_held_nxt   = 1'b0;
          w_rr_ptr_nxt = r_gnt_id;
        end
`else
        w_rr_ptr_nxt = r_gnt_id;
`endif
      end
      default: begin
        w_ack_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_q      <= RST_VAL;
      r_data   <= '0;
      r_ack    <= '0;
      r_gnt_id <= '0;
      r_rr_ptr <= LAST_ID;
`ifdef SHREG_LOCK_EN
      r_held   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_data   <= w_data_nxt;
      r_ack    <= w_ack_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
`ifdef SHREG_LOCK_EN
      r_held   <= w_held_nxt;
`endif
    end
  end

  assign bus.ack    = r_ack;
  assign bus.gnt_id = r_gnt_id;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.q      = r_q;

  a_ack_onehot: assert property (@(posedge clk) $onehot0(r_ack));
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus randomized requesters,
// all compared every cycle against a transaction-level reference model.
module tb_shared_reg_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam logic [DW-1:0] RST_VAL = 8'hA5;
`ifdef SHREG_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  shared_reg_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  shared_reg_arbiter #(.NREQ(NREQ), .DW(DW), .RST_VAL(RST_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: where the arbiter is in its 3-cycle transaction and what it should show.
  int              m_phase;
  logic [DW-1:0]   m_q;
  logic [DW-1:0]   m_data;
  logic [NREQ-1:0] m_ack;
  int              m_gnt;
  int              m_rr;
  bit              m_held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] get_wd(input int i);
    return bus.wdata[i*DW +: DW];
  endfunction

  task automatic set_wd(input int i, input logic [DW-1:0] v);
    bus.wdata[i*DW +: DW] = v;
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = 0;
      m_q     = RST_VAL;
      m_data  = '0;
      m_ack   = '0;
      m_gnt   = 0;
      m_rr    = NREQ - 1;
      m_held  = 1'b0;
      return;
    end
    case (m_phase)
      0: begin
        int win;
        win = -1;
        if (LOCK_EN && m_held && bus.req[m_gnt]) begin
          win = m_gnt;
        end else begin
          m_held = 1'b0;
          for (int k = 1; k <= NREQ; k++)
            if (win < 0 && bus.req[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
        end
        if (win >= 0) begin
          m_gnt   = win;
          m_data  = get_wd(win);
          m_phase = 1;
        end
      end
      1: begin
        m_q          = m_data;
        m_ack        = '0;
        m_ack[m_gnt] = 1'b1;
        m_phase      = 2;
      end
      default: begin
        m_ack = '0;
        if (LOCK_EN && bus.lock[m_gnt]) begin
          m_held = 1'b1;
        end else begin
          m_rr   = m_gnt;
          m_held = 1'b0;
        end
        m_phase = 0;
      end
    endcase
  endtask

  // One clock: model follows the edge, outputs are compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("ack",    32'(bus.ack),    32'(m_ack));
    check("busy",   32'(bus.busy),   32'(m_phase != 0));
    check("q",      32'(bus.q),      32'(m_q));
    check("gnt_id", 32'(bus.gnt_id), 32'(m_gnt));
  endtask

  task automatic wait_ack(output int id, output int cyc);
    id  = -1;
    cyc = 0;
    for (int n = 1; n <= 10 && id < 0; n++) begin
      tick();
      if (bus.ack != '0) begin
        id  = int'(bus.gnt_id);
        cyc = n;
      end
    end
    check("ack_seen", 32'(id >= 0), 32'd1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = '0;
    bus.lock = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin : stim
    int id, cyc;
    int exp_rr [5];
    exp_rr = '{0, 1, 2, 3, 0};

    rst       = 1'b1;
    bus.req   = '0;
    bus.wdata = '0;
    bus.lock  = '0;
    do_reset();
    check("rst_q",    32'(bus.q),    32'hA5);
    check("rst_ack",  32'(bus.ack),  32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);

    // Single write: busy in cycles 1-2, q and ack in cycle 2, ack gone in cycle 3.
    bus.req = 4'b0001;
    set_wd(0, 8'h3C);
    tick();
    check("t2_busy_c1", 32'(bus.busy), 32'd1);
    check("t2_ack_c1",  32'(bus.ack),  32'd0);
    tick();
    check("t2_q_c2",    32'(bus.q),    32'h3C);
    check("t2_ack_c2",  32'(bus.ack),  32'b0001);
    check("t2_busy_c2", 32'(bus.busy), 32'd1);
    bus.req = '0;
    tick();
    check("t2_ack_c3",  32'(bus.ack),  32'd0);
    check("t2_busy_c3", 32'(bus.busy), 32'd0);

    // A request arriving mid-transaction waits for the next IDLE.
    bus.req = 4'b0001;
    set_wd(0, 8'h11);
    tick();
    bus.req = 4'b0101;
    set_wd(2, 8'h5A);
    tick();
    check("t4_ack0", 32'(bus.ack), 32'b0001);
    check("t4_q0",   32'(bus.q),   32'h11);
    bus.req = 4'b0100;
    tick();
    tick();
    tick();
    check("t4_ack2", 32'(bus.ack), 32'b0100);
    check("t4_q2",   32'(bus.q),   32'h5A);
    bus.req = '0;
    tick();

    // Dropping req and changing wdata after the grant must not alter the committed write.
    bus.req = 4'b0001;
    set_wd(0, 8'h66);
    tick();
    bus.req = '0;
    set_wd(0, 8'hFF);
    tick();
    check("t5_q",   32'(bus.q),   32'h66);
    check("t5_ack", 32'(bus.ack), 32'b0001);
    tick();

    // Reset in the middle of a write.
    bus.req = 4'b0001;
    set_wd(0, 8'h77);
    tick();
    rst = 1'b1;
    tick();
    check("t1_midwrite_q",    32'(bus.q),    32'hA5);
    check("t1_midwrite_busy", 32'(bus.busy), 32'd0);
    rst     = 1'b0;
    bus.req = '0;
    tick();

    // All four requesting continuously: strict rotation, one ack every 3 cycles.
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_wd(i, DW'(8'h40 + i));
    for (int n = 0; n < 5; n++) begin
      wait_ack(id, cyc);
      check("t3_order", 32'(id), 32'(exp_rr[n]));
      check(n == 0 ? "t3_first_latency" : "t3_gap", 32'(cyc), n == 0 ? 32'd2 : 32'd3);
    end
    bus.req = '0;
    tick();

    // Grant retention: requester 0 locks once.
    do_reset();
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    set_wd(0, 8'hC0);
    set_wd(1, 8'hC1);
    wait_ack(id, cyc);
    check("t6_first", 32'(id), 32'd0);
    tick();
    bus.lock = '0;
    wait_ack(id, cyc);
    check("t6_second", 32'(id), LOCK_EN ? 32'd0 : 32'd1);
    if (LOCK_EN) begin
      wait_ack(id, cyc);
      check("t6_third", 32'(id), 32'd1);
    end
    bus.req = '0;
    tick();

    // Randomized requesters obeying the handshake, with occasional resets.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req[i] = 1'b1;
            set_wd(i, DW'($urandom));
          end
        end else if (bus.ack[i]) begin
          if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
          else set_wd(i, DW'($urandom));
        end
      end
      bus.lock = NREQ'($urandom);
      rst      = ($urandom_range(0, 99) == 0);
      tick();
      check("ack_onehot0", 32'($countones(bus.ack) <= 1), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
